numbers_hit_controller: RTL and testbench

Upstream control stage for the multiple-numbers display. It samples per-pixel overlap between the player sprite and each on-screen number during a frame. At each frame boundary it resolves at most one hit, pulses that number's `singleHit` line, and replaces the hit number's digit with a new pseudo-random value. It also accumulates the hit digit into a saturating 4-digit BCD score. It drives the display's `numbersToShow` and `singleHit` inputs and consumes the display's `numbersDR` and `showNum` outputs.

---
 rtl/numbers_pkg.sv | 23 ++
 rtl/numbers_hit_controller_lfsr16.sv | 17 +
 rtl/numbers_hit_controller.sv | 124 ++++++++++++
 tb/tb_numbers_hit_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/numbers_pkg.sv
// Shared types and constants for the numbers hit/score control path.
package numbers_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    RESOLVE,
    ADD,
    DONE
  } hit_state_t;

  typedef logic [3:0] digit_t;

  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam int          BCD_DIGITS = 4;
  localparam logic [15:0] SCORE_MAX  = 16'h9999;

  // Folds a raw nibble into 0-9; values 10-15 wrap to 0-5.
  function automatic digit_t lfsr_digit(input logic [3:0] raw);
    return (raw > 4'd9) ? digit_t'(raw - 4'd10) : raw;
  endfunction

endpackage

// File: rtl/numbers_hit_controller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; advances every clock, reusable by other game logic.
module lfsr16
  import numbers_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetN,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= SEED;
    else         state <= {state[14:0], ^(state & LFSR_TAPS)};
  end

endmodule

// File: rtl/numbers_hit_controller.sv
// Per-frame sprite/number hit resolution, digit replacement and saturating BCD score.
//
// state   | meaning
// COLLECT | accumulate collision flags, wait for start of frame
// RESOLVE | pick lowest snapshot hit, pulse it, reload its digit
// ADD     | ripple the hit digit into the score, one BCD digit per cycle
// DONE    | commit (or saturate) the score, honour a pending frame
module numbers_hit_controller
  import numbers_pkg::*;
#(
  parameter int          NUMBERS   = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   playerDR,
  input  logic [NUMBERS-1:0]     numbersDR,
  input  logic [NUMBERS-1:0]     showNum,
  output logic [NUMBERS-1:0]     singleHit,
  output logic [NUMBERS*4-1:0]   numbersToShow,
  output logic                   hitValid,
  output digit_t                 hitValue,
  output logic [15:0]            score
);

  logic [15:0]        lfsr;
  logic [NUMBERS-1:0] coll;
  logic [NUMBERS-1:0] flags;
  logic [NUMBERS-1:0] snap;
  logic [NUMBERS-1:0] pick;
  hit_state_t         state;
  logic               pending;
  logic               carry;
  logic [1:0]         digit_cnt;
  logic [15:0]        acc;
  digit_t             addend;
  digit_t             hit_digit;
  logic [4:0]         digit_sum;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .state  (lfsr)
  );

  assign coll = {NUMBERS{playerDR}} & numbersDR & showNum;
  assign pick = snap & (~snap + NUMBERS'(1));

  always_comb begin
    hit_digit = '0;
    for (int i = 0; i < NUMBERS; i++)
      if (pick[i]) hit_digit = numbersToShow[i*4 +: 4];
  end

  // acc rotates right each ADD cycle, so the active digit is always acc[3:0].
  assign addend    = (digit_cnt == 2'd0) ? hitValue : '0;
  assign digit_sum = {1'b0, acc[3:0]} + {1'b0, addend} + {4'd0, carry};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      flags <= '0;
      snap  <= '0;
    end else if (startOfFrame) begin
      snap  <= flags;
      flags <= coll;
    end else begin
      flags <= flags | coll;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= COLLECT;
      pending   <= 1'b0;
      carry     <= 1'b0;
      digit_cnt <= '0;
      acc       <= '0;
      score     <= '0;
      singleHit <= '0;
      hitValid  <= 1'b0;
      hitValue  <= '0;
      for (int i = 0; i < NUMBERS; i++)
        numbersToShow[i*4 +: 4] <= digit_t'((i + 1) % 10);
    end else begin
      singleHit <= '0;
      hitValid  <= 1'b0;
      case (state)
        COLLECT: if (startOfFrame) state <= RESOLVE;
        RESOLVE: begin
          if (snap != '0) begin
            singleHit <= pick;
            hitValid  <= 1'b1;
            hitValue  <= hit_digit;
            for (int i = 0; i < NUMBERS; i++)
              if (pick[i]) numbersToShow[i*4 +: 4] <= lfsr_digit(lfsr[3:0]);
            acc       <= score;
            carry     <= 1'b0;
            digit_cnt <= '0;
            if (startOfFrame) pending <= 1'b1;
            state     <= ADD;
          end else begin
            state <= startOfFrame ? RESOLVE : COLLECT;
          end
        end
        ADD: begin
          acc       <= {(digit_sum > 5'd9) ? digit_t'(digit_sum - 5'd10) : digit_sum[3:0],
                        acc[15:4]};
          carry     <= (digit_sum > 5'd9);
          digit_cnt <= digit_cnt + 2'd1;
          if (startOfFrame) pending <= 1'b1;
          if (digit_cnt == 2'(BCD_DIGITS - 1)) state <= DONE;
        end
        DONE: begin
          score   <= carry ? SCORE_MAX : acc;
          pending <= 1'b0;
          state   <= (pending || startOfFrame) ? RESOLVE : COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_numbers_hit_controller.sv
// Randomized self-checking bench for numbers_hit_controller against a frame-level reference model.
module tb_numbers_hit_controller;

  localparam int          N    = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic           clk = 1'b0;
  logic           resetN = 1'b0;
  logic           startOfFrame = 1'b0;
  logic           playerDR = 1'b0;
  logic [N-1:0]   numbersDR = '0;
  logic [N-1:0]   showNum = '0;
  logic [N-1:0]   singleHit;
  logic [N*4-1:0] numbersToShow;
  logic           hitValid;
  logic [3:0]     hitValue;
  logic [15:0]    score;

  numbers_hit_controller #(.NUMBERS(N), .LFSR_SEED(SEED)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .playerDR      (playerDR),
    .numbersDR     (numbersDR),
    .showNum       (showNum),
    .singleHit     (singleHit),
    .numbersToShow (numbersToShow),
    .hitValid      (hitValid),
    .hitValue      (hitValue),
    .score         (score)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: decimal score, digit per number, frame collision masks.
  int           score_m;
  int           num_m[N];
  logic [N-1:0] mask_m;
  logic [N-1:0] snap_m;
  int           lfsr_m;
  int           lfsr_prev;

  function automatic int next_lfsr(input int v);
    int fb;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v << 1) | fb) & 32'hFFFF;
  endfunction

  function automatic int fold(input int v);
    int n;
    n = v & 15;
    return (n > 9) ? n - 10 : n;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [N*4-1:0] exp_nums();
    logic [N*4-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'(num_m[i]);
    return r;
  endfunction

  // Counts the LFSR steps the DUT has taken; lfsr_prev is the value one edge earlier.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lfsr_m    <= int'(SEED);
      lfsr_prev <= int'(SEED);
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= next_lfsr(lfsr_m);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    score_m = 0;
    for (int i = 0; i < N; i++) num_m[i] = (i + 1) % 10;
    mask_m = '0;
    snap_m = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_single_hit"}, 32'(singleHit), 32'd0);
    check({tag, "_hit_valid"}, 32'(hitValid), 32'd0);
    check({tag, "_hit_value"}, 32'(hitValue), 32'd0);
    check({tag, "_score"}, 32'(score), 32'd0);
    check({tag, "_numbers"}, 32'(numbersToShow), 32'h321);
  endtask

  // Waits for the next falling edge, then applies inputs for the following rising edge.
  task automatic drive(input logic sof, input logic p, input logic [N-1:0] dr, input logic [N-1:0] sh);
    logic [N-1:0] coll;
    @(negedge clk);
    startOfFrame = sof;
    playerDR     = p;
    numbersDR    = dr;
    showNum      = sh;
    coll = {N{p}} & dr & sh;
    if (sof) begin
      snap_m = mask_m;
      mask_m = coll;
    end else begin
      mask_m = mask_m | coll;
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, N'($urandom), '1);
  endtask

  // Called right after the SOF cycle has been driven; follows the hit through T+7.
  task automatic resolve_frame();
    int           k;
    int           new_score;
    logic [N-1:0] exp_hit;
    k = -1;
    for (int i = 0; i < N; i++) if (snap_m[i] && k < 0) k = i;
    exp_hit = '0;
    if (k >= 0) exp_hit[k] = 1'b1;
    new_score = score_m;
    idle();
    check("early_pulse", 32'(singleHit), 32'd0);
    idle();
    check("single_hit", 32'(singleHit), 32'(exp_hit));
    check("hit_valid", 32'(hitValid), (k >= 0) ? 32'd1 : 32'd0);
    if (k >= 0) begin
      check("hit_value", 32'(hitValue), 32'(num_m[k]));
      new_score = score_m + num_m[k];
      if (new_score > 9999) new_score = 9999;
      num_m[k] = fold(lfsr_prev);
    end
    check("numbers", 32'(numbersToShow), 32'(exp_nums()));
    idle();
    check("pulse_end", {31'd0, hitValid}, 32'd0);
    check("pulse_end_hit", 32'(singleHit), 32'd0);
    repeat (3) idle();
    check("score_hold", 32'(score), 32'(to_bcd(score_m)));
    idle();
    score_m = new_score;
    check("score", 32'(score), 32'(to_bcd(score_m)));
  endtask

  task automatic hit_number(input int k);
    logic [N-1:0] oh;
    oh = '0;
    oh[k] = 1'b1;
    drive(1'b0, 1'b1, oh, '1);
    drive(1'b1, 1'b0, '0, '1);
    resolve_frame();
  endtask

  initial begin
    int best;
    int iter;
    int len;
    reset_model();
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    check_reset("reset");

    // Idle frames: nothing drawn over the player.
    for (int f = 0; f < 3; f++) begin
      repeat (10) idle();
      drive(1'b1, 1'b0, '0, '1);
      resolve_frame();
    end
    check("idle_numbers", 32'(numbersToShow), 32'h321);
    check("idle_score", 32'(score), 32'd0);

    // Number 1 overlapped for five pixels.
    repeat (5) drive(1'b0, 1'b1, 3'b010, '1);
    drive(1'b1, 1'b0, '0, '1);
    resolve_frame();

    // Numbers 0 and 2 in the same frame: lowest wins.
    repeat (3) drive(1'b0, 1'b1, 3'b101, '1);
    drive(1'b1, 1'b0, '0, '1);
    resolve_frame();

    // Hidden number cannot be hit.
    repeat (4) drive(1'b0, 1'b1, 3'b010, 3'b101);
    drive(1'b1, 1'b0, '0, '1);
    resolve_frame();

    // Collision only in the SOF cycle belongs to the next frame.
    repeat (4) idle();
    drive(1'b1, 1'b1, 3'b100, '1);
    resolve_frame();
    repeat (4) idle();
    drive(1'b1, 1'b0, '0, '1);
    resolve_frame();

    // Randomized frames.
    for (int f = 0; f < 60; f++) begin
      len = $urandom_range(3, 20);
      for (int c = 0; c < len; c++)
        drive(1'b0, ($urandom_range(0, 3) == 0), N'($urandom), ($urandom_range(0, 3) == 0) ? N'($urandom) : '1);
      drive(1'b1, ($urandom_range(0, 3) == 0), N'($urandom), '1);
      resolve_frame();
    end

    // Drive the score up to the top and past it.
    iter = 0;
    while (score_m < 9998 && iter < 3000) begin
      best = -1;
      for (int i = 0; i < N; i++)
        if (num_m[i] <= 9998 - score_m && (best < 0 || num_m[i] > num_m[best])) best = i;
      if (best < 0) best = 0;
      hit_number(best);
      iter++;
    end
    for (int h = 0; h < 3; h++) begin
      best = 0;
      for (int i = 1; i < N; i++) if (num_m[i] > num_m[best]) best = i;
      hit_number(best);
    end

    // Reset in the middle of ADD.
    drive(1'b0, 1'b1, 3'b001, '1);
    drive(1'b1, 1'b0, '0, '1);
    repeat (4) idle();
    resetN = 1'b0;
    startOfFrame = 1'b0;
    playerDR = 1'b0;
    #1;
    check_reset("midreset");
    reset_model();
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    repeat (10) idle();
    check_reset("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
